// File: rtl/output_pkg.sv
// Shared types and constants for the sequential display output path.
// Provides the converter FSM state type, active-low seven-segment codes
// (bit order gfedcba) and the helper that sizes the BCD accumulator.
package output_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Number of decimal digits needed to hold any width-bit unsigned value.
  function automatic int unsigned int_digits(input int unsigned width);
    return (width * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// One-digit seven-segment decoder, active-low, bit order gfedcba.
// Ports:
//   code_i  - BCD digit; codes above 9 display blank
//   blank_i - force blank
//   minus_i - force minus sign (highest priority)
//   seg_o   - segment drive, combinational
module bcd_seg_decoder
  import output_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (minus_i) begin
      seg_o = SEG_MINUS;
    end else if (!blank_i && (code_i <= 4'd9)) begin
      seg_o = SEG_DIGIT[code_i];
    end
  end

endmodule

// File: rtl/seq_output_unit.sv
// Sequential binary-to-BCD display driver. An iterative double-dabble engine
// converts one operand per WIDTH+1 cycles; the latched result is shown with
// leading-zero suppression, sign and overflow indication, or a raw BCD bus is
// shown instead.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   start, value     - conversion request and operand (sampled in IDLE only)
//   toggle, bcd_i    - 1 selects raw BCD display of bcd_i
//   busy, done       - conversion running / one-cycle result-latched pulse
//   overflow         - latched result does not fit the display
//   hex              - registered active-low segments, digit k at [7k+6:7k]
module seq_output_unit
  import output_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned SIGNED      = 1,
  parameter int unsigned BLANK_ZEROS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  toggle,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned INT_DIGITS = int_digits(WIDTH);
  localparam int unsigned PAD_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
  localparam int unsigned ACC_W      = 4 * INT_DIGITS;
  localparam int unsigned PAD_W      = 4 * PAD_DIGITS;
  localparam int unsigned CNT_W      = $clog2(WIDTH);
  localparam int unsigned IDX_W      = 4;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      sh_q, sh_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic                  res_neg_q, res_neg_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7*DIGITS-1:0]   hex_q;

  logic [ACC_W-1:0]      acc_adj;
  logic [PAD_W-1:0]      acc_pad;
  logic                  ovf_c;
  logic                  is_neg;
  logic [WIDTH-1:0]      mag;
  logic [IDX_W-1:0]      msd;
  logic [3:0]            dig_code  [DIGITS];
  logic [DIGITS-1:0]     dig_blank;
  logic [DIGITS-1:0]     dig_minus;
  logic [7*DIGITS-1:0]   seg_c;

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign hex      = hex_q;

  // Magnitude of the operand; the most negative value wraps onto itself,
  // which is the correct unsigned magnitude.
  assign is_neg = (SIGNED != 0) && value[WIDTH-1];
  assign mag    = is_neg ? (~value + WIDTH'(1)) : value;

  // Add-3 correction on every accumulator digit of 5 or more.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(INT_DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Overflow: digits beyond the display, or no room left for the sign.
  always_comb begin
    acc_pad = PAD_W'(acc_q);
    ovf_c   = 1'b0;
    for (int i = int'(DIGITS); i < int'(PAD_DIGITS); i++) begin
      if (acc_pad[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
    if (neg_q && (acc_pad[4*(DIGITS-1) +: 4] != 4'd0)) ovf_c = 1'b1;
  end

  // Converter FSM next-state and datapath.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    res_d     = res_q;
    res_neg_d = res_neg_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = mag;
          neg_d   = is_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {acc_d, sh_d} = {acc_adj[ACC_W-2:0], sh_q, 1'b0};
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        res_d     = acc_pad[4*DIGITS-1:0];
        res_neg_d = neg_q;
        ovf_d     = ovf_c;
        valid_d   = 1'b1;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CONV);
  end

  // Per-digit display selection: raw, blank-before-first-result, overflow,
  // or suppressed converted digits with sign placement.
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (res_q[4*i +: 4] != 4'd0) msd = IDX_W'(i);
    end
    for (int k = 0; k < int'(DIGITS); k++) begin
      dig_code[k]  = res_q[4*k +: 4];
      dig_blank[k] = 1'b0;
      dig_minus[k] = 1'b0;
      if (toggle) begin
        dig_code[k] = bcd_i[4*k +: 4];
      end else if (!valid_q) begin
        dig_blank[k] = 1'b1;
      end else if (ovf_q) begin
        dig_minus[k] = 1'b1;
      end else if (BLANK_ZEROS != 0) begin
        if (IDX_W'(k) > msd) begin
          if (res_neg_q && (IDX_W'(k) == msd + IDX_W'(1))) dig_minus[k] = 1'b1;
          else                                             dig_blank[k] = 1'b1;
        end
      end else if (res_neg_q && (k == int'(DIGITS) - 1)) begin
        dig_minus[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    bcd_seg_decoder u_dec (
      .code_i  (dig_code[g]),
      .blank_i (dig_blank[g]),
      .minus_i (dig_minus[g]),
      .seg_o   (seg_c[7*g +: 7])
    );
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      res_q     <= '0;
      res_neg_q <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hex_q     <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      res_q     <= res_d;
      res_neg_q <= res_neg_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hex_q     <= seg_c;
    end
  end

endmodule

// File: tb/tb_seq_output_unit.sv
// Scoreboard bench for seq_output_unit (WIDTH=32, DIGITS=6, signed, blanking).
module tb_seq_output_unit;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DIGITS = 6;

  logic        clk = 1'b0;
  logic        reset, start, toggle;
  logic [31:0] value;
  logic [23:0] bcd_i;
  logic        busy, done, overflow;
  logic [41:0] hex;

  seq_output_unit #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SIGNED(1), .BLANK_ZEROS(1)) dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .toggle(toggle),
    .bcd_i(bcd_i), .busy(busy), .done(done), .overflow(overflow), .hex(hex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
    int          dcyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  bit   mon_busy = 1'b0;
  int   n_done   = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_MINUS = {6{7'h3F}};

  function automatic logic [41:0] h6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: on each done pulse pop the expectation, check timing and
  // overflow, then check the registered display one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          mon_busy = 1'b1;
          check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.dcyc));
          check({e.name, "_overflow"}, 64'(overflow), 64'(e.ovf));
          @(negedge clk);
          check({e.name, "_done_width"}, 64'(done), 64'd0);
          check({e.name, "_hex"}, 64'(hex), 64'(e.hex));
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] v, input logic [41:0] eh,
                       input logic eo, input bit push);
    @(negedge clk);
    value = v;
    start = 1'b1;
    if (push) sb.push_back('{eh, eo, cyc + int'(WIDTH) + 2, name});
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || mon_busy || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  initial begin
    int d0, k;
    reset = 1'b1; start = 1'b0; toggle = 1'b0; value = '0; bcd_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_hex", 64'(hex), 64'(ALL_BLANK));

    issue("v1234", 32'd1234, h6(7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19), 1'b0, 1); drain();
    issue("vm57", 32'hFFFF_FFC7, h6(7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h12, 7'h78), 1'b0, 1); drain();
    issue("v0", 32'd0, h6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0, 1); drain();
    issue("vm99999", -32'sd99999, h6(7'h3F, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 1'b0, 1); drain();
    issue("v999999", 32'd999999, {6{7'h10}}, 1'b0, 1); drain();
    issue("vm100000", -32'sd100000, ALL_MINUS, 1'b1, 1); drain();
    issue("v1000000", 32'd1000000, ALL_MINUS, 1'b1, 1); drain();
    issue("vmin", 32'h8000_0000, ALL_MINUS, 1'b1, 1); drain();

    // Raw mode: registered, one cycle latency each way.
    @(negedge clk);
    toggle = 1'b1;
    bcd_i  = 24'h12345A;
    #1 check("raw_latency", 64'(hex), 64'(ALL_MINUS));
    @(negedge clk);
    check("raw_hex", 64'(hex), 64'(h6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F)));
    toggle = 1'b0;
    @(negedge clk);
    check("raw_back", 64'(hex), 64'(ALL_MINUS));

    // Reset mid-conversion: abort, blank display, clear overflow, no done.
    d0 = n_done;
    issue("abort", 32'd77, '0, 1'b0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hex", 64'(hex), 64'(ALL_BLANK));
    check("abort_ovf", 64'(overflow), 64'd0);

    // Start coincident with reset: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; value = 32'd5;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done), 64'(d0));

    // Starts during CONV (E+5) and DONE (E+33) are ignored.
    issue("ign", 32'd42, h6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24), 1'b0, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; value = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    start = 1'b1; value = 32'd8;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ign_idle", 64'(busy), 64'd0);

    // Back-to-back: next start accepted on the edge right after done.
    issue("b2b_a", 32'd305, h6(7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12), 1'b0, 1);
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_wait", 64'(k < 100), 64'd1);
    value = -32'sd8;
    start = 1'b1;
    sb.push_back('{h6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h00), 1'b0, cyc + int'(WIDTH) + 2, "b2b_b"});
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
